vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Shared-VRAM arbiter: video owns ce2H slots when enabled, and CPU/DMA share the
// remaining ce5 slots round-robin. Each access runs issue -> RAM -> capture -> ack.
module vram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce5,
    input  logic          ce2H,
    input  logic          vid_en,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd3;

    // Requester index 0 = CPU, 1 = DMA; owner code is index + 1.
    logic [1:0]    req_vec;
    logic [1:0]    we_vec;
    logic [AW-1:0] addr_arr  [2];
    logic [DW-1:0] wdata_arr [2];
    logic [DW-1:0] rdata_arr [2];
    logic [1:0]    busy_vec;
    logic [1:0]    ack_vec;
    logic [1:0]    elig;
    logic [1:0]    grant;

    logic          vid_slot;
    logic          shared_slot;
    logic          last_dma_reg;

    logic [1:0]    issue_owner;
    logic          issue_we;
    logic [AW-1:0] issue_addr;
    logic [DW-1:0] issue_wdata;

    logic          ram_en_reg;
    logic          ram_we_reg;
    logic [AW-1:0] ram_addr_reg;
    logic [DW-1:0] ram_wdata_reg;
    logic [1:0]    p1_owner_reg;
    logic          p1_we_reg;
    logic [1:0]    p2_owner_reg;
    logic          p2_we_reg;
    logic          vid_valid_reg;
    logic [DW-1:0] vid_data_reg;

    assign req_vec      = {dma_req, cpu_req};
    assign we_vec       = {dma_we, cpu_we};
    assign addr_arr[0]  = cpu_addr;
    assign addr_arr[1]  = dma_addr;
    assign wdata_arr[0] = cpu_wdata;
    assign wdata_arr[1] = dma_wdata;

    assign vid_slot    = ce5 & ce2H & vid_en;
    assign shared_slot = ce5 & ~vid_slot;
    assign elig        = req_vec & ~busy_vec;

    // last_dma_reg=1 means DMA won the previous contest, so CPU goes next.
    assign grant[0] = shared_slot & elig[0] & (~elig[1] | last_dma_reg);
    assign grant[1] = shared_slot & elig[1] & (~elig[0] | ~last_dma_reg);

    always_comb begin
        issue_owner = OWN_NONE;
        issue_we    = 1'b0;
        issue_addr  = ram_addr_reg;
        issue_wdata = ram_wdata_reg;
        if (vid_slot) begin
            issue_owner = OWN_VID;
            issue_addr  = vid_addr;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    issue_owner = 2'(i + 1);
                    issue_we    = we_vec[i];
                    issue_addr  = addr_arr[i];
                    issue_wdata = wdata_arr[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            p1_owner_reg  <= OWN_NONE;
            p1_we_reg     <= 1'b0;
            p2_owner_reg  <= OWN_NONE;
            p2_we_reg     <= 1'b0;
            last_dma_reg  <= 1'b1;
            vid_valid_reg <= 1'b0;
            vid_data_reg  <= '0;
        end else begin
            ram_en_reg    <= (issue_owner != OWN_NONE);
            ram_we_reg    <= issue_we;
            ram_addr_reg  <= issue_addr;
            ram_wdata_reg <= issue_wdata;
            p1_owner_reg  <= issue_owner;
            p1_we_reg     <= issue_we;
            p2_owner_reg  <= p1_owner_reg;
            p2_we_reg     <= p1_we_reg;
            if (|grant) begin
                last_dma_reg <= grant[1];
            end
            vid_valid_reg <= (p2_owner_reg == OWN_VID);
            if (p2_owner_reg == OWN_VID) begin
                vid_data_reg <= ram_rdata;
            end
        end
    end

    // Per-requester completion: busy spans grant..ack, rdata only moves on reads.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            localparam logic [1:0] OWN_ID = 2'(gi + 1);
            logic          busy_reg;
            logic          ack_reg;
            logic [DW-1:0] rdata_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    busy_reg  <= 1'b0;
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= (p2_owner_reg == OWN_ID);
                    if ((p2_owner_reg == OWN_ID) && !p2_we_reg) begin
                        rdata_reg <= ram_rdata;
                    end
                    if (grant[gi]) begin
                        busy_reg <= 1'b1;
                    end else if (ack_reg) begin
                        busy_reg <= 1'b0;
                    end
                end
            end

            assign busy_vec[gi]  = busy_reg;
            assign ack_vec[gi]   = ack_reg;
            assign rdata_arr[gi] = rdata_reg;
        end
    endgenerate

    assign ram_en    = ram_en_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign vid_valid = vid_valid_reg;
    assign vid_data  = vid_data_reg;
    assign cpu_ack   = ack_vec[0];
    assign dma_ack   = ack_vec[1];
    assign cpu_rdata = rdata_arr[0];
    assign dma_rdata = rdata_arr[1];

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: slot timing, round-robin, video slots, reset abort.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce5, ce2H, vid_en;
    logic [15:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int phase;
    int n_checks = 0;
    int n_pass   = 0;

    always #50 clk = ~clk;

    vram_arbiter #(.AW(16), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n), .ce5(ce5), .ce2H(ce2H), .vid_en(vid_en),
        .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Fixed RAM contents at the addresses the vectors use.
    function automatic logic [7:0] ram_model(input logic [15:0] a);
        case (a)
            16'h1234: return 8'hA5;
            16'h0040: return 8'h3C;
            16'h0100: return 8'h11;
            16'h0200: return 8'h22;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= ram_model(ram_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to mid-cycle of the next clock and present its slot strobes.
    task automatic step();
        @(negedge clk);
        phase = (phase + 1) % 8;
        ce5   = (phase % 2 == 0);
        ce2H  = (phase == 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 8'h0;
        ce5 = 1'b0; ce2H = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        phase   = 7;
    endtask

    int            exp_en_own [32];
    logic [15:0]   exp_addr   [32];
    int            exp_ack    [32];
    int            nsh;
    int            own;

    initial begin
        vid_en = 1'b1; vid_addr = 16'h0040; ram_rdata = 8'h0;
        do_reset();

        // Reset state
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_dma_ack", dma_ack, 0);
        check("rst_vid_valid", vid_valid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dma_rdata", dma_rdata, 0);
        check("rst_vid_data", vid_data, 0);

        // CPU read of 0x1234 in shared slot t2
        do_reset(); vid_en = 1'b1;
        step(); step();
        cpu_req = 1'b1; cpu_addr = 16'h1234;
        step();
        check("rd_en_S", ram_en, 0);
        step();
        check("rd_en_S1", ram_en, 1);
        check("rd_addr_S1", ram_addr, 16'h1234);
        check("rd_we_S1", ram_we, 0);
        step();
        check("rd_en_S2", ram_en, 0);
        step();
        check("rd_ack_S3", cpu_ack, 1);
        check("rd_data_S3", cpu_rdata, 8'hA5);
        check("rd_busy_no_regrant", ram_en, 0);
        cpu_req = 1'b0;
        step();
        check("rd_ack_once", cpu_ack, 0);
        step();
        check("rd_no_new", ram_en, 0);
        check("rd_hold", cpu_rdata, 8'hA5);

        // Round-robin with both requesters always asking
        for (int i = 0; i < 32; i++) begin
            exp_en_own[i] = 0; exp_addr[i] = 16'h0; exp_ack[i] = 0;
        end
        nsh = 0;
        for (int t = 0; t < 24; t += 2) begin
            if (t % 8 == 0) own = 3;
            else begin
                own = (nsh % 2 == 0) ? 1 : 2;
                nsh++;
            end
            exp_en_own[t+1] = own;
            exp_addr[t+1]   = (own == 3) ? 16'h0040 : (own == 1) ? 16'h0100 : 16'h0200;
            exp_ack[t+3]    = own;
        end
        do_reset(); vid_en = 1'b1; vid_addr = 16'h0040;
        cpu_req = 1'b1; cpu_addr = 16'h0100;
        dma_req = 1'b1; dma_addr = 16'h0200;
        for (int t = 0; t <= 24; t++) begin
            step();
            check($sformatf("rr_en_t%0d", t), ram_en, exp_en_own[t] != 0);
            if (exp_en_own[t] != 0) check($sformatf("rr_addr_t%0d", t), ram_addr, exp_addr[t]);
            check($sformatf("rr_cpu_ack_t%0d", t), cpu_ack, exp_ack[t] == 1);
            check($sformatf("rr_dma_ack_t%0d", t), dma_ack, exp_ack[t] == 2);
            check($sformatf("rr_vid_valid_t%0d", t), vid_valid, exp_ack[t] == 3);
            if (exp_ack[t] == 1) check("rr_cpu_rdata", cpu_rdata, 8'h11);
            if (exp_ack[t] == 2) check("rr_dma_rdata", dma_rdata, 8'h22);
            if (exp_ack[t] == 3) check("rr_vid_data", vid_data, 8'h3C);
        end

        // Video slot overrides a pending CPU request
        do_reset(); vid_en = 1'b1; vid_addr = 16'h0040;
        cpu_req = 1'b1; cpu_addr = 16'h1234;
        step();
        step();
        check("vid_en_S1", ram_en, 1);
        check("vid_addr_S1", ram_addr, 16'h0040);
        step();
        check("vid_en_S2", ram_en, 0);
        step();
        check("vid_valid_S3", vid_valid, 1);
        check("vid_data_S3", vid_data, 8'h3C);
        check("vid_cpu_next_en", ram_en, 1);
        check("vid_cpu_next_addr", ram_addr, 16'h1234);
        check("vid_no_cpu_ack", cpu_ack, 0);
        step(); step();
        check("vid_cpu_ack", cpu_ack, 1);
        check("vid_cpu_rdata", cpu_rdata, 8'hA5);
        cpu_req = 1'b0;

        // vid_en drops after a video issue; next ce2H slot is shared and carries a CPU write
        do_reset(); vid_en = 1'b1; vid_addr = 16'h0040;
        step();
        step();
        vid_en = 1'b0;
        step(); step();
        check("vdrop_valid", vid_valid, 1);
        check("vdrop_data", vid_data, 8'h3C);
        step(); step(); step(); step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h55;
        step();
        check("wr_en_S", ram_en, 0);
        step();
        check("wr_en_S1", ram_en, 1);
        check("wr_we_S1", ram_we, 1);
        check("wr_addr_S1", ram_addr, 16'h8000);
        check("wr_wdata_S1", ram_wdata, 8'h55);
        cpu_req = 1'b0;
        step();
        check("wr_we_S2", ram_we, 0);
        step();
        check("wr_ack_S3", cpu_ack, 1);
        check("wr_rdata_kept", cpu_rdata, 0);
        check("wr_no_vid_valid", vid_valid, 0);
        cpu_we = 1'b0;

        // Reset pulses: asynchronous clear in S+1, abort of an access in S+2
        do_reset(); vid_en = 1'b1;
        cpu_req = 1'b1; cpu_addr = 16'h0100;
        step(); step(); step(); step();
        check("ar_en_S1", ram_en, 1);
        reset_n = 1'b0;
        #1 check("ar_async_en", ram_en, 0);
        #1 reset_n = 1'b1;
        step();
        step();
        check("ar_regrant_en", ram_en, 1);
        step();
        reset_n = 1'b0;
        #1 check("ar_S2_en", ram_en, 0);
        step();
        check("ar_no_ack", cpu_ack, 0);
        check("ar_rdata_rst", cpu_rdata, 0);
        reset_n = 1'b1; vid_en = 1'b0;
        step();
        check("ar_no_ack_after", cpu_ack, 0);
        step();
        check("ar_first_slot_en", ram_en, 1);
        check("ar_first_slot_addr", ram_addr, 16'h0100);
        step(); step();
        check("ar_ack", cpu_ack, 1);
        check("ar_rdata", cpu_rdata, 8'h11);
        cpu_req = 1'b0;

        // CPU request held through ack: one access per slot pair
        do_reset(); vid_en = 1'b0;
        cpu_req = 1'b1; cpu_addr = 16'h0100;
        for (int t = 0; t < 16; t++) begin
            step();
            check($sformatf("hold_en_t%0d", t), ram_en, t % 4 == 1);
            check($sformatf("hold_ack_t%0d", t), cpu_ack, t % 4 == 3);
        end
        cpu_req = 1'b0;

        // ce2H without ce5 is ignored; request dropped before its slot is never granted
        do_reset(); vid_en = 1'b1; vid_addr = 16'h0040;
        step(); step();
        ce2H = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h1234;
        step();
        cpu_req = 1'b0;
        check("ign_ce2h_en", ram_en, 0);
        step();
        check("drop_no_grant", ram_en, 0);
        step();
        check("ign_no_extra_vid", vid_valid, 0);
        check("drop_no_ack", cpu_ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
